dcp_tx_arbiter: RTL and testbench

// - Shares the single debug transmit path (req_tx/type_tx/dout/ack_tx) between N_REQ DCP command units (T, D, I, B, ...).
// - Selects one requester round-robin and forwards its word and type to the transmitter. Routes ack_tx back to the grantee.
// - A lock input keeps the grant across a multi-word dump, e.g. the nine-register T dump, so the dump is not interleaved.

---
 rtl/dcp_tx_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_dcp_tx_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dcp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// dcp_tx_arbiter
//
// Shares the single debug transmit path (req_tx/type_tx/dout/ack_tx) between
// N_REQ DCP command units. One requester is granted round-robin. Its type and
// data word are forwarded to the transmitter, and ack_tx is routed back to it
// alone. A per-requester lock keeps the grant across a multi-word dump, so the
// words of one dump are never interleaved with another unit's traffic.
//
// Optional feature macro: DCP_ARB_TIMEOUT_EN
//   When defined, an ack watchdog aborts a transfer that stays in ISSUE for
//   TIMEOUT_CYC cycles without ack_tx. It pulses err_timeout on abort. When
//   undefined, ISSUE waits forever and err_timeout is constant 0.
//
// Parameters
//   N_REQ        number of requesters (2..8)
//   DATA_W       width of each data word
//   TYPE_W       width of the type field
//   TIMEOUT_CYC  watchdog limit in cycles (only with DCP_ARB_TIMEOUT_EN)
//
// Ports
//   clk          system clock
//   rstn         synchronous active-low reset
//   req_in       per-requester transmit request (level, held until its ack)
//   lock_in      per-requester burst lock, sampled when the grantee releases
//   type_in      per-requester type, slice i = [i*TYPE_W +: TYPE_W]
//   din          per-requester data, slice i = [i*DATA_W +: DATA_W]
//   ack_out      ack_tx routed to the grantee only
//   gnt          one-hot registered grant, all-zero when idle
//   req_tx       request to the shared transmitter
//   type_tx      type of the granted requester
//   dout         data word of the granted requester
//   ack_tx       transmitter acknowledge (one or more cycles)
//   busy         high whenever the arbiter is not idle
//   err_timeout  one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module dcp_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 32,
  parameter int TYPE_W      = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_REQ-1:0]          req_in,
  input  logic [N_REQ-1:0]          lock_in,
  input  logic [N_REQ*TYPE_W-1:0]   type_in,
  input  logic [N_REQ*DATA_W-1:0]   din,
  output logic [N_REQ-1:0]          ack_out,
  output logic [N_REQ-1:0]          gnt,
  output logic                      req_tx,
  output logic [TYPE_W-1:0]         type_tx,
  output logic [DATA_W-1:0]         dout,
  input  logic                      ack_tx,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_REL = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_gidx;
  logic [N_REQ-1:0]   r_gnt;
  logic               r_req_tx;
  logic               r_busy;
  logic               r_err_timeout;

  logic               w_any;
  logic [IDX_W-1:0]   w_win;
  logic               w_g_req;
  logic               w_g_lock;
  logic               w_tmo;
  logic [TYPE_W-1:0]  w_type;
  logic [DATA_W-1:0]  w_dout;

  // Index following idx, wrapping at N_REQ (N_REQ need not be a power of 2).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] v;
    if (idx == IDX_W'(N_REQ - 1)) begin
      v = {IDX_W{1'b0}};
    end else begin
      v = idx + IDX_W'(1);
    end
    return v;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = {N_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin winner: first requesting index scanning ptr, ptr+1, ...
  // The scan runs from the farthest offset down so the nearest one wins.
  always_comb begin
    int s;
    w_any = 1'b0;
    w_win = r_ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      s = int'(r_ptr) + i;
      s = (s >= N_REQ) ? (s - N_REQ) : s;
      if (req_in[IDX_W'(s)]) begin
        w_any = 1'b1;
        w_win = IDX_W'(s);
      end else begin
        w_any = w_any;
      end
    end
  end

  assign w_g_req  = req_in[r_gidx];
  assign w_g_lock = lock_in[r_gidx];

  // Grantee slice mux. The one-hot grant masks every slice, so the result is zero when idle.
  always_comb begin
    w_type = {TYPE_W{1'b0}};
    w_dout = {DATA_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      w_type = w_type | (type_in[i*TYPE_W +: TYPE_W] & {TYPE_W{r_gnt[i]}});
      w_dout = w_dout | (din[i*DATA_W +: DATA_W] & {DATA_W{r_gnt[i]}});
    end
  end

`ifdef DCP_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] r_cnt;

  // Ack watchdog: cleared on every entry to ISSUE, counts ISSUE cycles without ack.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == ST_IDLE && w_any) || (r_state == ST_HOLD && w_g_req)) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_state == ST_ISSUE && !ack_tx) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign w_tmo = (r_state == ST_ISSUE) && !ack_tx && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC > 0);
  assign w_tmo        = 1'b0;
`endif

  // Arbiter FSM with registered grant, request, busy and error outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_ptr         <= {IDX_W{1'b0}};
      r_gidx        <= {IDX_W{1'b0}};
      r_gnt         <= {N_REQ{1'b0}};
      r_req_tx      <= 1'b0;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= onehot(w_win);
            r_gidx  <= w_win;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Once the request is up the transmitter owns the transfer, so a
          // requester dropping req_in here does not withdraw req_tx.
          if (ack_tx) begin
            r_req_tx <= 1'b0;
            r_state  <= ST_WAIT_REL;
          end else if (w_tmo) begin
            // Abort ignores lock: the stuck unit loses its grant.
            r_err_timeout <= 1'b1;
            r_req_tx      <= 1'b0;
            r_gnt         <= {N_REQ{1'b0}};
            r_ptr         <= next_idx(r_gidx);
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_req_tx <= 1'b1;
          end
        end
        ST_WAIT_REL: begin
          if (!ack_tx && !w_g_req) begin
            if (w_g_lock) begin
              r_state <= ST_HOLD;
            end else begin
              r_gnt   <= {N_REQ{1'b0}};
              r_ptr   <= next_idx(r_gidx);
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (w_g_req) begin
            r_state <= ST_ISSUE;
          end else if (!w_g_lock) begin
            r_gnt   <= {N_REQ{1'b0}};
            r_ptr   <= next_idx(r_gidx);
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_gnt    <= {N_REQ{1'b0}};
          r_req_tx <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // ack_tx reaches the grantee only while its transfer is open (ISSUE or WAIT_REL),
  // so a held ack is forwarded for its whole duration. An ack in IDLE or HOLD is dropped.
  assign ack_out     = (r_state == ST_ISSUE || r_state == ST_WAIT_REL) ?
                       (r_gnt & {N_REQ{ack_tx}}) : {N_REQ{1'b0}};
  assign gnt         = r_gnt;
  assign req_tx      = r_req_tx;
  assign type_tx     = w_type;
  assign dout        = w_dout;
  assign busy        = r_busy;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_dcp_tx_arbiter.sv
module tb_dcp_tx_arbiter;

  logic         clk;
  logic         rstn;
  logic [3:0]   req_in;
  logic [3:0]   lock_in;
  logic [7:0]   type_in;
  logic [127:0] din;
  logic [3:0]   ack_out;
  logic [3:0]   gnt;
  logic         req_tx;
  logic [1:0]   type_tx;
  logic [31:0]  dout;
  logic         ack_tx;
  logic         busy;
  logic         err_timeout;

  logic [31:0]  d_slot [4];
  logic [1:0]   t_of   [4];
  logic [31:0]  d_of   [4];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic        ack;
    logic [3:0]  e_gnt;
    logic        e_req_tx;
    logic [3:0]  e_ack;
    logic        e_busy;
    logic [1:0]  e_type;
    logic [31:0] e_dout;
  } vec_t;

  vec_t vecs[$];

  assign din     = {d_slot[3], d_slot[2], d_slot[1], d_slot[0]};
  assign type_in = {t_of[3], t_of[2], t_of[1], t_of[0]};

  dcp_tx_arbiter #(
    .N_REQ(4), .DATA_W(32), .TYPE_W(2), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rstn(rstn), .req_in(req_in), .lock_in(lock_in),
    .type_in(type_in), .din(din), .ack_out(ack_out), .gnt(gnt),
    .req_tx(req_tx), .type_tx(type_tx), .dout(dout), .ack_tx(ack_tx),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                              input logic ack, input logic [3:0] e_gnt, input logic e_req_tx,
                              input logic [3:0] e_ack, input logic e_busy,
                              input logic [1:0] e_type, input logic [31:0] e_dout);
    vec_t v;
    v.rst = rst; v.req = req; v.lock = lock; v.ack = ack;
    v.e_gnt = e_gnt; v.e_req_tx = e_req_tx; v.e_ack = e_ack; v.e_busy = e_busy;
    v.e_type = e_type; v.e_dout = e_dout;
    return v;
  endfunction

  initial begin
    int order [6];
    logic [3:0] oh;

    t_of = '{2'b10, 2'b11, 2'b01, 2'b00};
    d_of = '{32'h000000A0, 32'h000000A1, 32'h00000007, 32'h000000A3};
    for (int i = 0; i < 4; i++) d_slot[i] = d_of[i];
    rstn = 1'b0; req_in = 4'b1111; lock_in = 4'b0000; ack_tx = 1'b0;

    // Reset with every requester asking: all outputs zero, then grant 0, then req_tx.
    tick();
    chk("rst gnt", 32'(gnt), 32'h0);
    chk("rst req_tx", 32'(req_tx), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst err", 32'(err_timeout), 32'h0);
    chk("rst ack_out", 32'(ack_out), 32'h0);
    chk("rst dout", dout, 32'h0);
    rstn = 1'b1;
    tick();
    chk("rel gnt", 32'(gnt), 32'h1);
    chk("rel req_tx", 32'(req_tx), 32'h0);
    tick();
    chk("rel+1 req_tx", 32'(req_tx), 32'h1);
    chk("rel+1 dout", dout, 32'h000000A0);

    // Single transfer from requester 2, then pointer check (ptr=3 picks 3 over 0).
    vecs.push_back(mk(1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 32'h0));
    vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'b01, 32'h7));
    vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1, 2'b01, 32'h7));
    vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'b01, 32'h7));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'b01, 32'h7));
    vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 32'h0));
    vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'b00, 32'hA3));

    // Round robin with 1011 requesting: expected grant order 0,1,3,0,1,3.
    order = '{0, 1, 3, 0, 1, 3};
    for (int k = 0; k < 6; k++) begin
      oh = 4'b0001 << order[k];
      vecs.push_back(mk((k == 0), 4'b1011, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 32'h0));
      vecs.push_back(mk(1'b0, 4'b1011, 4'b0000, 1'b0, oh, 1'b0, 4'b0000, 1'b1, t_of[order[k]], d_of[order[k]]));
      vecs.push_back(mk(1'b0, 4'b1011, 4'b0000, 1'b1, oh, 1'b1, oh, 1'b1, t_of[order[k]], d_of[order[k]]));
      vecs.push_back(mk(1'b0, 4'b1011 & ~oh, 4'b0000, 1'b0, oh, 1'b0, 4'b0000, 1'b1, t_of[order[k]], d_of[order[k]]));
    end

    // Held ack for 3 cycles on requester 1; requester 0 waits; ack in IDLE ignored.
    vecs.push_back(mk(1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 32'h0));
    vecs.push_back(mk(1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'b11, 32'hA1));
    vecs.push_back(mk(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'b11, 32'hA1));
    vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'b11, 32'hA1));
    vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'b11, 32'hA1));
    vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'b11, 32'hA1));
    vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 32'h0));
    vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'b10, 32'hA0));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      req_in = vecs[i].req; lock_in = vecs[i].lock; ack_tx = vecs[i].ack;
      #2;
      chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d req_tx", i), 32'(req_tx), 32'(vecs[i].e_req_tx));
      chk($sformatf("v%0d ack_out", i), 32'(ack_out), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d type_tx", i), 32'(type_tx), 32'(vecs[i].e_type));
      chk($sformatf("v%0d dout", i), dout, vecs[i].e_dout);
      tick();
    end

    // Locked nine-word burst from requester 0 while requester 1 waits.
    ack_tx = 1'b0;
    do_reset();
    req_in = 4'b0011; lock_in = 4'b0001; d_slot[0] = 32'h1;
    tick();
    for (int w = 1; w <= 9; w++) begin
      ack_tx = 1'b0; req_in = 4'b0011;
      #2;
      chk($sformatf("burst w%0d gnt", w), 32'(gnt), 32'h1);
      chk($sformatf("burst w%0d dout", w), dout, 32'(w));
      tick();
      ack_tx = 1'b1;
      #2;
      chk($sformatf("burst w%0d req_tx", w), 32'(req_tx), 32'h1);
      chk($sformatf("burst w%0d ack_out", w), 32'(ack_out), 32'h1);
      tick();
      ack_tx = 1'b0; req_in = 4'b0010; lock_in = (w == 9) ? 4'b0000 : 4'b0001;
      #2;
      chk($sformatf("burst w%0d rel gnt", w), 32'(gnt), 32'h1);
      tick();
      if (w < 9) begin
        d_slot[0] = 32'(w + 1); ack_tx = 1'b1; req_in = 4'b0011;
        #2;
        chk($sformatf("burst w%0d hold gnt", w), 32'(gnt), 32'h1);
        chk($sformatf("burst w%0d hold ack_out", w), 32'(ack_out), 32'h0);
        chk($sformatf("burst w%0d hold req_tx", w), 32'(req_tx), 32'h0);
        tick();
      end
    end
    #2;
    chk("burst end gnt", 32'(gnt), 32'h0);
    chk("burst end busy", 32'(busy), 32'h0);
    tick();
    chk("burst next gnt", 32'(gnt), 32'h2);
    chk("burst next dout", dout, 32'h000000A1);

    // Transfer never acknowledged.
    do_reset();
    req_in = 4'b0011; lock_in = 4'b0000; ack_tx = 1'b0;
    tick();
    chk("stall gnt", 32'(gnt), 32'h1);
`ifdef DCP_ARB_TIMEOUT_EN
    for (int j = 1; j <= 15; j++) begin
      tick();
      chk($sformatf("tmo c%0d err", j), 32'(err_timeout), 32'h0);
    end
    tick();
    chk("tmo err pulse", 32'(err_timeout), 32'h1);
    chk("tmo req_tx", 32'(req_tx), 32'h0);
    chk("tmo gnt", 32'(gnt), 32'h0);
    tick();
    chk("tmo err clear", 32'(err_timeout), 32'h0);
    chk("tmo next gnt", 32'(gnt), 32'h2);
`else
    for (int j = 1; j <= 40; j++) begin
      tick();
      chk($sformatf("stall c%0d err", j), 32'(err_timeout), 32'h0);
    end
    chk("stall hold gnt", 32'(gnt), 32'h1);
    chk("stall hold req_tx", 32'(req_tx), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
